// File: rtl/rotary_quad_decoder_pkg.sv
// Shared types and constants for the rotary encoder front end.
package rotary_quad_decoder_pkg;

    // Quadrature tracking states; every 3-bit code is assigned.
    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_DETENT = 3'd1,
        ST_CW1    = 3'd2,
        ST_CW2    = 3'd3,
        ST_CW3    = 3'd4,
        ST_CCW1   = 3'd5,
        ST_CCW2   = 3'd6,
        ST_CCW3   = 3'd7
    } rqd_state_t;

    // Filtered {A,B} codes; clockwise order is 00 -> 01 -> 11 -> 10 -> 00.
    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

endpackage

// File: rtl/rotary_quad_decoder_debounce_filter.sv
// Synchroniser plus stability counter for one raw asynchronous input.
// The filtered output only follows the synchronised input after it has
// differed from the current filtered value for DEBOUNCE_CYCLES consecutive
// clocks; any shorter excursion resets the count.
module rotary_quad_decoder_debounce_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign dout     = r_filt;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive mismatching clocks; load the new level when the count completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_synced == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: filters A, B and PRESS, tracks the quadrature
// sequence and emits one-clock inc/dec/press/seq_err pulses.
//
// state   | meaning
// RESYNC  | position unknown, waiting for AB=00
// DETENT  | resting at a detent (AB=00)
// CW1     | clockwise, AB=01 seen
// CW2     | clockwise, AB=11 seen
// CW3     | clockwise, AB=10 seen; 00 completes a detent (inc)
// CCW1    | counter-clockwise, AB=10 seen
// CCW2    | counter-clockwise, AB=11 seen
// CCW3    | counter-clockwise, AB=01 seen; 00 completes a detent (dec)
module rotary_quad_decoder
    import rotary_quad_decoder_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic rot_a,
    input  logic rot_b,
    input  logic rot_press,
    output logic inc,
    output logic dec,
    output logic press,
    output logic seq_err
);

    logic       w_filt_a;
    logic       w_filt_b;
    logic       w_filt_press;
    logic [1:0] w_ab;

    rqd_state_t r_state;
    logic       r_inc;
    logic       r_dec;
    logic       r_seq_err;
    logic       r_press_prev;
    logic       r_press;

    rotary_quad_decoder_debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk  (clk),
        .reset(reset),
        .din  (rot_a),
        .dout (w_filt_a)
    );

    rotary_quad_decoder_debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk  (clk),
        .reset(reset),
        .din  (rot_b),
        .dout (w_filt_b)
    );

    rotary_quad_decoder_debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_press (
        .clk  (clk),
        .reset(reset),
        .din  (rot_press),
        .dout (w_filt_press)
    );

    assign w_ab    = {w_filt_a, w_filt_b};
    assign inc     = r_inc;
    assign dec     = r_dec;
    assign press   = r_press;
    assign seq_err = r_seq_err;

    // Quadrature state machine with registered detent and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RESYNC;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_seq_err <= 1'b0;
            case (r_state)
                ST_RESYNC: begin
                    if (w_ab == AB_00) r_state <= ST_DETENT;
                end
                ST_DETENT: begin
                    case (w_ab)
                        AB_01:   r_state <= ST_CW1;
                        AB_10:   r_state <= ST_CCW1;
                        AB_11:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_CW1: begin
                    case (w_ab)
                        AB_11:   r_state <= ST_CW2;
                        AB_00:   r_state <= ST_DETENT;
                        AB_10:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_CW2: begin
                    case (w_ab)
                        AB_10:   r_state <= ST_CW3;
                        AB_01:   r_state <= ST_CW1;
                        AB_00:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_CW3: begin
                    case (w_ab)
                        AB_00:   begin r_state <= ST_DETENT; r_inc <= 1'b1; end
                        AB_11:   r_state <= ST_CW2;
                        AB_01:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_CCW1: begin
                    case (w_ab)
                        AB_11:   r_state <= ST_CCW2;
                        AB_00:   r_state <= ST_DETENT;
                        AB_01:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_CCW2: begin
                    case (w_ab)
                        AB_01:   r_state <= ST_CCW3;
                        AB_10:   r_state <= ST_CCW1;
                        AB_00:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_CCW3: begin
                    case (w_ab)
                        AB_00:   begin r_state <= ST_DETENT; r_dec <= 1'b1; end
                        AB_11:   r_state <= ST_CCW2;
                        AB_10:   begin r_state <= ST_RESYNC; r_seq_err <= 1'b1; end
                        default: ;
                    endcase
                end
                default: r_state <= ST_RESYNC;
            endcase
        end
    end

    // Pulse once on the filtered rising edge of the push-button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_press_prev <= 1'b0;
            r_press      <= 1'b0;
        end else begin
            r_press_prev <= w_filt_press;
            r_press      <= w_filt_press & ~r_press_prev;
        end
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Directed bench for rotary_quad_decoder with an event scoreboard.
module tb_rotary_quad_decoder;

    localparam int LAT = 7;   // 2 sync + 4 debounce + 1 output register

    localparam int K_INC   = 0;
    localparam int K_DEC   = 1;
    localparam int K_PRESS = 2;
    localparam int K_ERR   = 3;
    localparam int K_NONE  = -1;

    typedef struct {
        int kind;
        int cyc;
    } evt_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rot_a = 1'b0;
    logic rot_b = 1'b0;
    logic rot_press = 1'b0;
    logic inc, dec, press, seq_err;

    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    evt_t exp_q[$];

    rotary_quad_decoder #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rot_a    (rot_a),
        .rot_b    (rot_b),
        .rot_press(rot_press),
        .inc      (inc),
        .dec      (dec),
        .press    (press),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_INC:   return "inc";
            K_DEC:   return "dec";
            K_PRESS: return "press";
            K_ERR:   return "seq_err";
            default: return "none";
        endcase
    endfunction

    task automatic check_evt(input int k);
        evt_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: got %s at cycle %0d, expected no pulse", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                fails++;
                $display("FAIL pulse_match: got %s at cycle %0d, expected %s at cycle %0d",
                         kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every pulse seen must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (inc && dec) begin
                tests++;
                fails++;
                $display("FAIL inc_dec_overlap: inc=%0b dec=%0b at cycle %0d, expected not both", inc, dec, cyc);
            end
            if (inc)     check_evt(K_INC);
            if (dec)     check_evt(K_DEC);
            if (press)   check_evt(K_PRESS);
            if (seq_err) check_evt(K_ERR);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int k);
        evt_t e;
        e.kind = k;
        e.cyc  = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [1:0] ab, input int k);
        rot_a = ab[1];
        rot_b = ab[0];
        if (k != K_NONE) expect_evt(k);
        hold(10);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        tests++;
        if (inc !== 1'b0)     begin fails++; $display("FAIL %s_inc: got %b, expected 0", tag, inc); end
        tests++;
        if (dec !== 1'b0)     begin fails++; $display("FAIL %s_dec: got %b, expected 0", tag, dec); end
        tests++;
        if (press !== 1'b0)   begin fails++; $display("FAIL %s_press: got %b, expected 0", tag, press); end
        tests++;
        if (seq_err !== 1'b0) begin fails++; $display("FAIL %s_seq_err: got %b, expected 0", tag, seq_err); end
    endtask

    task automatic full_cw;
        step(2'b01, K_NONE);
        step(2'b11, K_NONE);
        step(2'b10, K_NONE);
        step(2'b00, K_INC);
    endtask

    initial begin
        // 1: reset, then idle at 00 so the FSM reaches DETENT
        hold(3);
        check_reset_outputs("reset1");
        @(posedge clk); #1;
        reset = 1'b0;
        hold(20);

        // 2: three clockwise detents
        for (int i = 0; i < 3; i++) full_cw();

        // 3: one counter-clockwise detent, then a partial that backs out
        step(2'b10, K_NONE);
        step(2'b11, K_NONE);
        step(2'b01, K_NONE);
        step(2'b00, K_DEC);
        step(2'b01, K_NONE);
        step(2'b00, K_NONE);

        // 4: glitches are rejected, a long press yields one pulse
        rot_a = 1'b1; hold(2); rot_a = 1'b0; hold(10);
        rot_press = 1'b1; hold(3); rot_press = 1'b0; hold(10);
        rot_press = 1'b1; expect_evt(K_PRESS); hold(10);
        rot_press = 1'b0; hold(10);

        // 5: illegal jump, resync through CW tail, then a clean detent
        step(2'b11, K_ERR);
        step(2'b10, K_NONE);
        step(2'b00, K_NONE);
        full_cw();

        // 6: reset while in CW2 discards the partial detent
        step(2'b01, K_NONE);
        step(2'b11, K_NONE);
        reset = 1'b1;
        check_reset_outputs("reset2");
        @(posedge clk); #1;
        reset = 1'b0;
        // filters restart at 00 so the FSM sits at DETENT, then sees the held 11
        expect_evt(K_ERR);
        hold(10);
        step(2'b10, K_NONE);
        step(2'b00, K_NONE);
        full_cw();

        hold(20);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0 outstanding (next %s at cycle %0d)",
                     exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
